branch_hazard_scoreboard: RTL and testbench
===========================================

# branch_hazard_scoreboard

Parametrised hazard unit that replaces fixed EX/MEM register-compare stall logic with a per-register scoreboard. It sits beside the ID stage and tracks every in-flight register write by remaining latency and pipeline age. From that state it produces the ID stall, the ID-stage branch-comparator forwarding selects, and a stall-cycle performance counter. It supports configurable ALU and load latencies, pipeline depth, and EX-stage flush.

## Interface
Parameters:
- NREG, 32, architectural register count; r0 is never tracked
- RW, 5, register index width, $clog2(NREG)
- ALU_LAT, 1, cycles after issue before an ALU result is forwardable to ID
- LOAD_LAT, 2, same for loads; LOAD_LAT >= ALU_LAT
- EX_SLACK, 1, latency a non-branch consumer tolerates, since its operands are forwarded later in EX
- DEPTH, 3, producer stages after ID (EX, MEM, WB); DEPTH >= LOAD_LAT+1
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction moves ID->EX this cycle (0 = bubble)
- issue_regwrite  in  1  issuing instruction writes a register
- issue_memread  in  1  issuing instruction is a load
- issue_wreg  in  RW  destination of issuing instruction
- flush_ex  in  1  kill the instruction currently in EX
- id_valid  in  1  ID holds a real instruction
- id_branch  in  1  ID instruction is a branch resolved in ID
- id_use_rs, id_use_rt  in  1 each  operand is read
- id_rs, id_rt  in  RW  source registers
- stall  out  1  hold IF/ID and issue a bubble
- stall_br  out  1  stall caused by a branch operand
- fwd_sel_rs, fwd_sel_rt  out  $clog2(DEPTH)  ID comparator source: 0 regfile, k = pipeline register after stage k
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Per-register state for r in 1..NREG-1:
  - cnt[r]: remaining latency, 0 = ready
  - age[r]: 1..DEPTH+1, where DEPTH+1 = retired/idle
- Issue (issue_valid & issue_regwrite & issue_wreg!=0) sets:
  - cnt[w] = issue_memread ? LOAD_LAT : ALU_LAT
  - age[w] = 1
- Issue overwrites any older in-flight writer of w (WAW: youngest wins).
- Every cycle, for registers not being issued:
  - cnt decrements if nonzero.
  - age increments, saturating at DEPTH+1.
  - Decrement and age increment run regardless of stall.
- flush_ex: every register with age==1 (before the edge) gets cnt=0 and age=DEPTH+1.
- Same-edge flush and issue to the same register: issue wins.
- Operand hazard for operand x with register r:
  - id_valid & id_use_x & r!=0 & cnt[r] > (id_branch ? 0 : EX_SLACK)
- stall = OR of operand hazards. stall_br = stall & id_branch.
- stall does not depend on issue_valid (no combinational loop).
- fwd_sel_x:
  - age[r]-1 when 2 <= age[r] <= DEPTH, r!=0, and cnt[r]==0.
  - Otherwise 0. The regfile is write-before-read, so age DEPTH+1 reads the regfile.
  - Meaningful only when id_branch and !stall.
- stall_count increments on each cycle with stall=1 and saturates at all-ones.

## Timing
- stall, stall_br, fwd_sel_*: combinational from current state and ID inputs, same cycle.
- State updates on the rising clk edge.
- Default parameters:
  - ALU producer, then branch consumer next cycle: 1 stall cycle, then fwd_sel=1.
  - Load producer, then branch: 2 stall cycles, then fwd_sel=2.
  - Load, then non-branch consumer: 1 stall cycle.
  - ALU, then non-branch consumer: 0 stall cycles.
- Reset, asynchronous, any time, including mid-stall:
  - All cnt=0, all age=DEPTH+1, stall_count=0.
  - Hence stall=0, stall_br=0, fwd_sel=0 while rst_n=0.
- The first edge after rst_n deasserts is a normal update.

## Structure
- Shared package hazard_pkg holds:
  - fwd select constants FWD_REGFILE=0, FWD_EXMEM=1, FWD_MEMWB=2
  - a function computing the consumer threshold
- One sub-module, hazard_sb_entry: per-register cnt/age state with issue, flush and decrement. It is instantiated NREG-1 times via generate.
- Top level holds the read-side muxes, the stall OR, and stall_count.

## Test plan
- ALU writes r5 (cnt 1), next cycle beq reads r5 -> stall=stall_br=1 for 1 cycle; following cycle stall=0, fwd_sel_rs=1.
- lw r8, then bne reading r8 as rt -> stall 2 cycles; then fwd_sel_rt=2; stall_count=2.
- lw r3, then add reading r3 -> stall 1 cycle, stall_br=0; ALU r3 then add -> stall never asserts.
- ALU to r0 followed by beq r0 -> no stall, fwd_sel=0.
- lw r4 issued, flush_ex next cycle -> r4 cleared; beq r4 following -> no stall. Same edge: flush plus new issue of ALU to r4 -> r4 cnt=1, so beq stalls 1 cycle.
- lw r9, then ALU r9 issued while the load is in EX (WAW), branch reads r9 -> stall governed by the younger ALU entry. Assert rst_n=0 mid-stall -> stall and stall_count drop to 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Purpose: shared constants and helpers for the branch hazard scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  // ID comparator source selects: 0 = regfile, k = pipeline register after stage k.
  localparam int FWD_REGFILE = 0;
  localparam int FWD_EXMEM   = 1;
  localparam int FWD_MEMWB   = 2;

  // Remaining latency a consumer can absorb. A branch compares in ID and
  // needs the value now; other consumers pick operands up later in EX.
  function automatic int consumerThreshold(input logic isBranch, input int exSlack);
    return isBranch ? 0 : exSlack;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// Purpose: per-register scoreboard entry tracking remaining latency and pipeline age.
// Latency: state updates on the rising clk edge; outputs are the registered state.
// Backpressure: none; decrement and aging run every cycle regardless of stall.
// Ports: clk, rst_n; issueHit/issueLoad = a writer of this register issues (load or ALU);
//        flush = kill the instruction in EX; cnt = remaining latency; age = 1..DEPTH+1.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int CW       = 2,
  parameter int AW       = 3,
  parameter int DEPTH    = 3,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issueHit,
  input  logic          issueLoad,
  input  logic          flush,
  output logic [CW-1:0] cnt,
  output logic [AW-1:0] age
);

  localparam logic [CW-1:0] ALU_CNT  = CW'(ALU_LAT);
  localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_LAT);
  localparam logic [AW-1:0] AGE_EX   = AW'(1);
  localparam logic [AW-1:0] AGE_IDLE = AW'(DEPTH + 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      age <= AGE_IDLE;
    end else if (issueHit) begin
      // A new writer replaces any older in-flight one, and beats a same-edge flush.
      cnt <= issueLoad ? LOAD_CNT : ALU_CNT;
      age <= AGE_EX;
    end else if (flush && age == AGE_EX) begin
      // Writer was in EX and is being killed: the register falls back to the regfile.
      cnt <= '0;
      age <= AGE_IDLE;
    end else begin
      if (cnt != '0)
        cnt <= cnt - CW'(1);
      if (age != AGE_IDLE)
        age <= age + AW'(1);
    end
  end

endmodule

// File: rtl/branch_hazard_scoreboard.sv
// Purpose: ID-stage hazard unit: stall, branch forwarding selects, stall counter from a per-register scoreboard.
// Latency: stall/stall_br/fwd_sel_* combinational same cycle; scoreboard and counter update on rising clk.
// Backpressure: stall holds IF/ID and forces a bubble; it never depends on issue_valid.
// Ports: issue_* = instruction leaving ID; flush_ex kills EX; id_* = instruction in ID;
//        stall/stall_br, fwd_sel_rs/rt (0 regfile, k = after stage k), stall_count (saturating).
module branch_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int RW       = 5,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int EX_SLACK = 1,
  parameter int DEPTH    = 3,
  parameter int CNT_W    = 32,
  localparam int FW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             issue_regwrite,
  input  logic             issue_memread,
  input  logic [RW-1:0]    issue_wreg,
  input  logic             flush_ex,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  output logic             stall,
  output logic             stall_br,
  output logic [FW-1:0]    fwd_sel_rs,
  output logic [FW-1:0]    fwd_sel_rt,
  output logic [CNT_W-1:0] stall_count
);

  localparam int CW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
  localparam int AW = $clog2(DEPTH + 2);
  localparam logic [AW-1:0] AGE_IDLE = AW'(DEPTH + 1);

  logic [NREG-1:0][CW-1:0] cntArr;
  logic [NREG-1:0][AW-1:0] ageArr;
  logic                    issueEn;

  assign issueEn = issue_valid & issue_regwrite;

  // r0 is hardwired: always ready and reads the regfile.
  assign cntArr[0] = '0;
  assign ageArr[0] = AGE_IDLE;

  for (genvar r = 1; r < NREG; r++) begin : gEntry
    hazard_sb_entry #(
      .CW      (CW),
      .AW      (AW),
      .DEPTH   (DEPTH),
      .ALU_LAT (ALU_LAT),
      .LOAD_LAT(LOAD_LAT)
    ) uEntry (
      .clk      (clk),
      .rst_n    (rst_n),
      .issueHit (issueEn && (issue_wreg == RW'(r))),
      .issueLoad(issue_memread),
      .flush    (flush_ex),
      .cnt      (cntArr[r]),
      .age      (ageArr[r])
    );
  end

  // A value is forwardable once its latency has elapsed and it still sits in a
  // pipeline register; after that the write-before-read regfile supplies it.
  function automatic logic [FW-1:0] fwdOf(input logic [RW-1:0] r,
                                          input logic [CW-1:0] c,
                                          input logic [AW-1:0] a);
    if (r != '0 && c == '0 && a >= AW'(2) && a <= AW'(DEPTH))
      return FW'(a - AW'(1));
    return FW'(FWD_REGFILE);
  endfunction

  logic [CW-1:0] cntRs, cntRt;
  logic [AW-1:0] ageRs, ageRt;
  logic          hazRs, hazRt;
  int            thr;

  always_comb begin
    cntRs = cntArr[id_rs];
    cntRt = cntArr[id_rt];
    ageRs = ageArr[id_rs];
    ageRt = ageArr[id_rt];
    thr   = consumerThreshold(id_branch, EX_SLACK);
    hazRs = id_valid && id_use_rs && (id_rs != '0) && (int'(cntRs) > thr);
    hazRt = id_valid && id_use_rt && (id_rt != '0) && (int'(cntRt) > thr);
  end

  assign stall      = hazRs | hazRt;
  assign stall_br   = stall & id_branch;
  assign fwd_sel_rs = fwdOf(id_rs, cntRs, ageRs);
  assign fwd_sel_rt = fwdOf(id_rt, cntRt, ageRt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && stall_count != '1)
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_branch_hazard_scoreboard.sv
// Purpose: self-checking bench for branch_hazard_scoreboard using an expectation queue.
// Latency: inputs driven 1 time unit after posedge, outputs compared at the following negedge.
// Backpressure: n/a.
module tb_branch_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0, issue_regwrite = 1'b0, issue_memread = 1'b0;
  logic [4:0]  issue_wreg = '0;
  logic        flush_ex = 1'b0;
  logic        id_valid = 1'b0, id_branch = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0;
  logic        stall, stall_br;
  logic [1:0]  fwd_sel_rs, fwd_sel_rt;
  logic [31:0] stall_count;

  branch_hazard_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_regwrite(issue_regwrite),
    .issue_memread (issue_memread),
    .issue_wreg    (issue_wreg),
    .flush_ex      (flush_ex),
    .id_valid      (id_valid),
    .id_branch     (id_branch),
    .id_use_rs     (id_use_rs),
    .id_use_rt     (id_use_rt),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .stall         (stall),
    .stall_br      (stall_br),
    .fwd_sel_rs    (fwd_sel_rs),
    .fwd_sel_rt    (fwd_sel_rt),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        st;
    logic        br;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic [31:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  int   expCnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Compare one queued expectation per cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      chk({e.tag, ".stall"},    {31'd0, stall},       {31'd0, e.st});
      chk({e.tag, ".stall_br"}, {31'd0, stall_br},    {31'd0, e.br});
      chk({e.tag, ".fwd_rs"},   {30'd0, fwd_sel_rs},  {30'd0, e.frs});
      chk({e.tag, ".fwd_rt"},   {30'd0, fwd_sel_rt},  {30'd0, e.frt});
      chk({e.tag, ".count"},    stall_count,          e.cnt);
    end
  end

  // One cycle of stimulus plus its expected outputs.
  task automatic cyc(input string tag,
                     input logic iv, input logic irw, input logic imr, input logic [4:0] iw,
                     input logic fl,
                     input logic idv, input logic idb, input logic urs, input logic urt,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic es, input logic [1:0] frs, input logic [1:0] frt);
    @(posedge clk);
    #1;
    issue_valid = iv; issue_regwrite = irw; issue_memread = imr; issue_wreg = iw;
    flush_ex = fl;
    id_valid = idv; id_branch = idb; id_use_rs = urs; id_use_rt = urt;
    id_rs = rs; id_rt = rt;
    expQ.push_back('{tag, es, es & idb, frs, frt, 32'(expCnt)});
    if (es) expCnt++;
  endtask

  // Async reset pulse between edges; ID inputs are left as they were.
  task automatic rstPulse(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_regwrite = 1'b0; issue_memread = 1'b0; flush_ex = 1'b0;
    expCnt = 0;
    expQ.push_back('{tag, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0});
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with ID already reading a register
    id_valid = 1'b1; id_branch = 1'b1; id_use_rs = 1'b1; id_rs = 5'd7;
    rstPulse("reset");

    // ALU r5 -> beq r5: one stall, then EX/MEM, then MEM/WB, then regfile
    cyc("alu_r5",      1,1,0,5'd5,0, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("beq_r5_s",    0,0,0,5'd0,0, 1,1,1,0,5'd5,5'd0, 1,2'd0,2'd0);
    cyc("beq_r5_f1",   0,0,0,5'd0,0, 1,1,1,0,5'd5,5'd0, 0,2'd1,2'd0);
    cyc("beq_r5_f2",   0,0,0,5'd0,0, 1,1,0,1,5'd0,5'd5, 0,2'd0,2'd2);
    cyc("beq_r5_rf",   0,0,0,5'd0,0, 1,1,0,1,5'd0,5'd5, 0,2'd0,2'd0);
    rstPulse("reset2");

    // lw r8 -> bne rt=r8: two stalls, then MEM/WB, count 2
    cyc("lw_r8",       1,1,1,5'd8,0, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("bne_r8_s1",   0,0,0,5'd0,0, 1,1,0,1,5'd0,5'd8, 1,2'd0,2'd0);
    cyc("bne_r8_s2",   0,0,0,5'd0,0, 1,1,0,1,5'd0,5'd8, 1,2'd0,2'd0);
    cyc("bne_r8_f2",   0,0,0,5'd0,0, 1,1,0,1,5'd0,5'd8, 0,2'd0,2'd2);

    // lw r3 -> add: one non-branch stall; ALU r3 -> add: none
    cyc("lw_r3",       1,1,1,5'd3,0, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("add_r3_s",    0,0,0,5'd0,0, 1,0,1,0,5'd3,5'd0, 1,2'd0,2'd0);
    cyc("add_r3_ok",   0,0,0,5'd0,0, 1,0,1,0,5'd3,5'd0, 0,2'd0,2'd0);
    cyc("alu_r3",      1,1,0,5'd3,0, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("add_r3_alu",  0,0,0,5'd0,0, 1,0,1,0,5'd3,5'd0, 0,2'd0,2'd0);

    // r0 is never tracked
    cyc("alu_r0",      1,1,0,5'd0,0, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("beq_r0",      0,0,0,5'd0,0, 1,1,1,1,5'd0,5'd0, 0,2'd0,2'd0);

    // flush kills the load in EX
    cyc("lw_r4",       1,1,1,5'd4,0, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("flush_r4",    0,0,0,5'd0,1, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("beq_r4_clr",  0,0,0,5'd0,0, 1,1,1,0,5'd4,5'd0, 0,2'd0,2'd0);
    // same-edge flush and issue: issue wins
    cyc("lw_r4b",      1,1,1,5'd4,0, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("flush_alu4",  1,1,0,5'd4,1, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("beq_r4_s",    0,0,0,5'd0,0, 1,1,1,0,5'd4,5'd0, 1,2'd0,2'd0);
    cyc("beq_r4_f1",   0,0,0,5'd0,0, 1,1,1,0,5'd4,5'd0, 0,2'd1,2'd0);

    // flush leaves a load that has already moved past EX
    cyc("lw_r11",      1,1,1,5'd11,0, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("idle_r11",    0,0,0,5'd0,0,  0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("flush_r11",   0,0,0,5'd0,1,  1,1,0,1,5'd0,5'd11, 1,2'd0,2'd0);
    cyc("beq_r11_f2",  0,0,0,5'd0,0,  1,1,0,1,5'd0,5'd11, 0,2'd0,2'd2);

    // WAW: younger ALU writer governs r9
    cyc("lw_r9",       1,1,1,5'd9,0, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("alu_r9_waw",  1,1,0,5'd9,0, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("beq_r9_s",    0,0,0,5'd0,0, 1,1,1,0,5'd9,5'd0, 1,2'd0,2'd0);
    cyc("beq_r9_f1",   0,0,0,5'd0,0, 1,1,1,0,5'd9,5'd0, 0,2'd1,2'd0);

    // reset in the middle of a load stall
    cyc("lw_r9b",      1,1,1,5'd9,0, 0,0,0,0,5'd0,5'd0, 0,2'd0,2'd0);
    cyc("beq_r9_s2",   0,0,0,5'd0,0, 1,1,1,0,5'd9,5'd0, 1,2'd0,2'd0);
    rstPulse("mid_stall_rst");
    cyc("beq_r9_post", 0,0,0,5'd0,0, 1,1,1,0,5'd9,5'd0, 0,2'd0,2'd0);

    @(negedge clk);
    #1;
    chk("drain", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
